// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Redirects from EX flush IF/ID to a bubble; stalls freeze PC and IF/ID.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_pc_plus4_o,
    output logic                  id_valid_o,
    output logic [31:0]           fetch_count_o
);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_REDIRECT
    } fetch_action_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    fetch_action_t         action;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  count_saturated;

    assign imem_addr_o     = pc;
    assign pc_plus4        = pc + PC_STEP;
    assign redirect_target = redirect_pc_i & ALIGN_MASK;
    assign count_saturated = (fetch_count_o == '1);

    // Redirect wins over stall: the stalled instruction is on the wrong path anyway.
    always_comb begin
        action = ACT_ADVANCE;
        if (redirect_i) begin
            action = ACT_REDIRECT;
        end else if (stall_i) begin
            action = ACT_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC & ALIGN_MASK;
            id_instr_o    <= NOP_INSTR;
            id_pc_o       <= '0;
            id_pc_plus4_o <= '0;
            id_valid_o    <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    pc            <= redirect_target;
                    id_instr_o    <= NOP_INSTR;
                    id_pc_o       <= '0;
                    id_pc_plus4_o <= '0;
                    id_valid_o    <= 1'b0;
                end
                ACT_ADVANCE: begin
                    pc            <= pc_plus4;
                    id_instr_o    <= imem_instr_i;
                    id_pc_o       <= pc;
                    id_pc_plus4_o <= pc_plus4;
                    id_valid_o    <= 1'b1;
                    if (!count_saturated) begin
                        fetch_count_o <= fetch_count_o + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
